// File: rtl/sap_ctrl_pkg.sv
// sap_ctrl_pkg: shared opcodes, control-bit indices and one-hot T-states for the SAP-1 sequencer
package sap_ctrl_pkg;

    localparam int CW_WIDTH = 12;
    localparam int NUM_T    = 6;

    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam int CW_CP = 11;
    localparam int CW_EP = 10;
    localparam int CW_LM = 9;
    localparam int CW_CE = 8;
    localparam int CW_LI = 7;
    localparam int CW_EI = 6;
    localparam int CW_LA = 5;
    localparam int CW_EA = 4;
    localparam int CW_SU = 3;
    localparam int CW_EU = 2;
    localparam int CW_LB = 1;
    localparam int CW_LO = 0;

    typedef enum logic [NUM_T-1:0] {
        T1 = 6'b000001,
        T2 = 6'b000010,
        T3 = 6'b000100,
        T4 = 6'b001000,
        T5 = 6'b010000,
        T6 = 6'b100000
    } t_state_e;

endpackage

// File: rtl/decoder_4line_16line.sv
// decoder_4line_16line: one-hot 4-to-16 decoder with output enable
module decoder_4line_16line (
    input  logic        o_en,
    input  logic [3:0]  sel,
    output logic [15:0] y
);

    // one output line per select value, all low when disabled
    always_comb begin
        y = o_en ? (16'h0001 << sel) : 16'h0000;
    end

endmodule

// File: rtl/ring_counter_6.sv
// ring_counter_6: one-hot T-state ring with enable, clear-to-zero and load-T1
module ring_counter_6
    import sap_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             load_t1,
    output logic [NUM_T-1:0] q
);

    // reset wins, then halt clear, then early wrap, then normal rotation
    always_ff @(posedge clk) begin
        if (rst)
            q <= T1;
        else if (clr)
            q <= '0;
        else if (load_t1)
            q <= T1;
        else if (en)
            q <= {q[NUM_T-2:0], q[NUM_T-1]};
    end

endmodule

// File: rtl/sap_control_sequencer.sv
// sap_control_sequencer: SAP-1 T-state sequencer and control word generator (option: SEQ_EARLY_FETCH_EN)
module sap_control_sequencer
    import sap_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                run_en,
    input  logic                step,
    input  logic [3:0]          opcode,
    output logic [CW_WIDTH-1:0] ctrl_word,
    output logic [NUM_T-1:0]    t_state,
    output logic                halted,
    output logic                instr_done
);

    logic [15:0]         dec;
    logic                dec_en;
    logic                adv;
    logic                last;
    logic                halt_now;
    logic                load_t1;
    logic                is_lda, is_add, is_sub, is_out, is_hlt, is_nop, is_mem;
    logic [CW_WIDTH-1:0] cw;

    assign dec_en = ~halted;

    decoder_4line_16line u_dec (
        .o_en (dec_en),
        .sel  (opcode),
        .y    (dec)
    );

    ring_counter_6 u_ring (
        .clk     (clk),
        .rst     (rst),
        .en      (adv),
        .clr     (halt_now),
        .load_t1 (load_t1),
        .q       (t_state)
    );

    // opcode classes, advance qualifier and end-of-instruction detection
    always_comb begin
        is_lda   = dec[OP_LDA];
        is_add   = dec[OP_ADD];
        is_sub   = dec[OP_SUB];
        is_out   = dec[OP_OUT];
        is_hlt   = dec[OP_HLT];
        is_nop   = |dec[13:3];
        is_mem   = is_lda | is_add | is_sub;
        adv      = (run_en | step) & ~halted;
        halt_now = adv & t_state[3] & is_hlt;
`ifdef SEQ_EARLY_FETCH_EN
        last     = (t_state[2] & is_nop) | (t_state[3] & is_out) |
                   (t_state[4] & is_lda) | (t_state[5] & (is_add | is_sub));
        load_t1  = adv & last;
`else
        last     = t_state[5];
        load_t1  = 1'b0;
`endif
        instr_done = adv & last;
    end

    // control word from T-state and decoded opcode, gated so held cycles issue nothing
    always_comb begin
        cw        = '0;
        cw[CW_EP] = t_state[0];
        cw[CW_LM] = t_state[0] | (t_state[3] & is_mem);
        cw[CW_CP] = t_state[1];
        cw[CW_CE] = t_state[2] | (t_state[4] & is_mem);
        cw[CW_LI] = t_state[2];
        cw[CW_EI] = t_state[3] & is_mem;
        cw[CW_LA] = (t_state[4] & is_lda) | (t_state[5] & (is_add | is_sub));
        cw[CW_LB] = t_state[4] & (is_add | is_sub);
        cw[CW_EU] = t_state[5] & (is_add | is_sub);
        cw[CW_SU] = t_state[5] & is_sub;
        cw[CW_EA] = t_state[3] & is_out;
        cw[CW_LO] = t_state[3] & is_out;
        ctrl_word = adv ? cw : '0;
    end

    // halt latches on leaving T4 of HLT and only reset releases it
    always_ff @(posedge clk) begin
        if (rst)
            halted <= 1'b0;
        else if (halt_now)
            halted <= 1'b1;
    end

endmodule

// File: tb/tb_sap_control_sequencer.sv
// tb_sap_control_sequencer: directed self-checking bench for sap_control_sequencer
module tb_sap_control_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        run_en;
    logic        step;
    logic [3:0]  opcode;
    logic [11:0] ctrl_word;
    logic [5:0]  t_state;
    logic        halted;
    logic        instr_done;

    int total = 0;
    int bad   = 0;

`ifdef SEQ_EARLY_FETCH_EN
    localparam int N_LDA = 5;
    localparam int N_OUT = 4;
`else
    localparam int N_LDA = 6;
    localparam int N_OUT = 6;
`endif

    logic [11:0] lda_cw [6] = '{12'h600, 12'h800, 12'h180, 12'h240, 12'h120, 12'h000};
    logic [11:0] add_cw [6] = '{12'h600, 12'h800, 12'h180, 12'h240, 12'h102, 12'h024};
    logic [11:0] sub_cw [6] = '{12'h600, 12'h800, 12'h180, 12'h240, 12'h102, 12'h02C};
    logic [11:0] out_cw [6] = '{12'h600, 12'h800, 12'h180, 12'h011, 12'h000, 12'h000};

    sap_control_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .run_en     (run_en),
        .step       (step),
        .opcode     (opcode),
        .ctrl_word  (ctrl_word),
        .t_state    (t_state),
        .halted     (halted),
        .instr_done (instr_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        run_en = 1'b0;
        step   = 1'b0;
        opcode = 4'h0;
        do_reset();
        total++;
        if (t_state !== 6'b000001) begin
            bad++;
            $display("FAIL reset_t_state got=%h want=01", t_state);
        end
        total++;
        if (halted !== 1'b0) begin
            bad++;
            $display("FAIL reset_halted got=%b want=0", halted);
        end
        total++;
        if (ctrl_word !== 12'h000) begin
            bad++;
            $display("FAIL reset_hold_cw got=%h want=000", ctrl_word);
        end
    endtask

    task automatic run_seq(input string name, input logic [3:0] op, input int n, input logic [11:0] exp_cw [6]);
        do_reset();
        run_en = 1'b1;
        opcode = op;
        #1;
        for (int i = 0; i < n; i++) begin
            total++;
            if (t_state !== (6'b000001 << i)) begin
                bad++;
                $display("FAIL %s_t_state[%0d] got=%h want=%h", name, i, t_state, 6'b000001 << i);
            end
            total++;
            if (ctrl_word !== exp_cw[i]) begin
                bad++;
                $display("FAIL %s_cw[%0d] got=%h want=%h", name, i, ctrl_word, exp_cw[i]);
            end
            total++;
            if (instr_done !== (i == n - 1)) begin
                bad++;
                $display("FAIL %s_done[%0d] got=%b want=%b", name, i, instr_done, i == n - 1);
            end
            tick();
        end
        total++;
        if (t_state !== 6'b000001) begin
            bad++;
            $display("FAIL %s_wrap got=%h want=01", name, t_state);
        end
        run_en = 1'b0;
    endtask

    task automatic test_lda();
        run_seq("lda", 4'h0, N_LDA, lda_cw);
    endtask

    task automatic test_alu();
        run_seq("sub", 4'h2, 6, sub_cw);
        run_seq("add", 4'h1, 6, add_cw);
    endtask

    task automatic test_out();
        run_seq("out", 4'hE, N_OUT, out_cw);
    endtask

    task automatic test_step();
        int k;
        do_reset();
        run_en = 1'b0;
        opcode = 4'h1;
        k = 0;
        for (int p = 0; p < 8; p++) begin
            for (int c = 0; c < 5; c++) begin
                step = (c == 0);
                #1;
                total++;
                if (t_state !== (6'b000001 << k)) begin
                    bad++;
                    $display("FAIL step_t_state[%0d.%0d] got=%h want=%h", p, c, t_state, 6'b000001 << k);
                end
                total++;
                if (ctrl_word !== (step ? add_cw[k] : 12'h000)) begin
                    bad++;
                    $display("FAIL step_cw[%0d.%0d] got=%h want=%h", p, c, ctrl_word, step ? add_cw[k] : 12'h000);
                end
                tick();
                if (c == 0)
                    k = (k + 1) % 6;
            end
        end
        step = 1'b0;
    endtask

    task automatic test_halt();
        do_reset();
        run_en = 1'b1;
        opcode = 4'hF;
        tick();
        tick();
        tick();
        total++;
        if (t_state !== 6'b001000 || ctrl_word !== 12'h000) begin
            bad++;
            $display("FAIL hlt_t4 got=%h/%h want=08/000", t_state, ctrl_word);
        end
        tick();
        for (int i = 0; i < 20; i++) begin
            run_en = i[0];
            step   = i[1];
            #1;
            total++;
            if (halted !== 1'b1 || t_state !== 6'b000000 || ctrl_word !== 12'h000 || instr_done !== 1'b0) begin
                bad++;
                $display("FAIL hlt_hold[%0d] got=%b/%h/%h/%b want=1/00/000/0", i, halted, t_state, ctrl_word, instr_done);
            end
            tick();
        end
        step   = 1'b0;
        run_en = 1'b1;
        do_reset();
        total++;
        if (t_state !== 6'b000001 || halted !== 1'b0) begin
            bad++;
            $display("FAIL hlt_release got=%h/%b want=01/0", t_state, halted);
        end
        total++;
        if (ctrl_word !== 12'h600) begin
            bad++;
            $display("FAIL hlt_release_cw got=%h want=600", ctrl_word);
        end
        run_en = 1'b0;
    endtask

    task automatic test_rst_mid();
        do_reset();
        run_en = 1'b1;
        opcode = 4'h1;
        for (int i = 0; i < 4; i++)
            tick();
        total++;
        if (t_state !== 6'b010000 || ctrl_word !== 12'h102) begin
            bad++;
            $display("FAIL mid_t5 got=%h/%h want=10/102", t_state, ctrl_word);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        total++;
        if (t_state !== 6'b000001) begin
            bad++;
            $display("FAIL mid_restart got=%h want=01", t_state);
        end
        total++;
        if (ctrl_word !== 12'h600) begin
            bad++;
            $display("FAIL mid_restart_cw got=%h want=600", ctrl_word);
        end
        run_en = 1'b0;
    endtask

    initial begin
        rst    = 1'b1;
        run_en = 1'b0;
        step   = 1'b0;
        opcode = 4'h0;
        test_reset();
        test_lda();
        test_alu();
        test_step();
        test_halt();
        test_rst_mid();
        test_out();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
